// File: rtl/dma_ahb_cfg_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cram_dma_pkg
//  Description : Shared definitions for the DMA configuration bridge.
//                Holds the DMA register offsets, AHB-Lite encodings and the
//                bridge FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cram_dma_pkg;

   // DMA register word offsets inside the 4 KB slot
   localparam logic [11:0] REG_RD_ADDR = 12'h000;
   localparam logic [11:0] REG_WR_ADDR = 12'h004;
   localparam logic [11:0] REG_LENGTH  = 12'h008;
   localparam logic [11:0] REG_STEP    = 12'h00C;
   localparam logic [11:0] REG_CTRL    = 12'h010;

   // AHB-Lite encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // Data-phase state of the bridge
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD_HOLD = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_DONE = 3'd4,
      ST_ERR1    = 3'd5,
      ST_ERR2    = 3'd6
   } state_e;

endpackage
`default_nettype wire

// File: rtl/dma_ahb_cfg_bridge_if.sv
`default_nettype none
// ============================================================================
//  Interface   : dma_ahb_cfg_bridge_if
//  Description : AHB-Lite slave port of the DMA configuration bridge.
//  Signals     : HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0],
//                HWDATA[31:0], HREADY      (master -> slave)
//                HREADYOUT, HRESP, HRDATA[31:0]   (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dma_ahb_cfg_bridge_if;

   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );

endinterface
`default_nettype wire

// File: rtl/dma_ahb_cfg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dma_ahb_cfg_bridge
//  Description : AHB-Lite slave in front of the DMA configuration port.
//                Writes are posted (zero wait) and committed one cycle after
//                their data phase as a single dma_write_o strobe. Reads take
//                a two-cycle data phase; an extra hold cycle is inserted when
//                a posted write is committing. Illegal accesses get a
//                two-cycle ERROR response and never touch the registers.
//  Ports       : clk_i, rst_i          clock, async active-high reset
//                bus                   AHB-Lite slave interface
//                dma_addr_o            DMA register offset
//                dma_write_o           one-cycle register write strobe
//                dma_wdata_o           DMA register write data
//                dma_rdata_i           DMA register read data (comb. of addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_ahb_cfg_bridge
   import cram_dma_pkg::*;
#(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] REG_LAST = 12'h010
) (
   input  wire                    clk_i,
   input  wire                    rst_i,
   dma_ahb_cfg_bridge_if.slave    bus,
   output logic [ADDR_W-1:0]      dma_addr_o,
   output logic                   dma_write_o,
   output logic [DATA_W-1:0]      dma_wdata_o,
   input  wire  [DATA_W-1:0]      dma_rdata_i
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;          // address captured at accept
   logic [ADDR_W-1:0]   dma_addr_q, dma_addr_d;
   logic                dma_write_q, dma_write_d;
   logic [DATA_W-1:0]   dma_wdata_q, dma_wdata_d;
   logic [DATA_W-1:0]   hrdata_q, hrdata_d;

   logic accept;
   logic illegal;

   assign accept  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
   assign illegal = (bus.HSIZE != HSIZE_WORD) ||
                    (bus.HADDR[1:0] != 2'b00) ||
                    (bus.HADDR[ADDR_W-1:0] > REG_LAST);

   // Upper address bits select the 4 KB slot in the interconnect only.
   wire unused_bits = &{1'b0, bus.HADDR[31:ADDR_W], bus.HTRANS[0]};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dma_addr_d  = dma_addr_q;
      dma_write_d = 1'b0;
      dma_wdata_d = dma_wdata_q;
      hrdata_d    = hrdata_q;

      case (state_q)
         ST_RD_HOLD: begin
            // The posted write owned dma_addr_o this cycle; now drive the read.
            state_d    = ST_RD_ADDR;
            dma_addr_d = addr_q;
         end
         ST_RD_ADDR: begin
            state_d  = ST_RD_DONE;
            hrdata_d = dma_rdata_i;
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            // IDLE, WR, RD_DONE, ERR2: HREADYOUT is high, transfer boundary.
            if (state_q == ST_WR) begin
               // End of write data phase: load the single-entry post buffer,
               // which is exactly the strobe/address/data register set.
               dma_write_d = 1'b1;
               dma_addr_d  = addr_q;
               dma_wdata_d = bus.HWDATA[DATA_W-1:0];
            end
            state_d = ST_IDLE;
            if (accept) begin
               addr_d = bus.HADDR[ADDR_W-1:0];
               if (illegal) begin
                  state_d = ST_ERR1;
               end else if (bus.HWRITE) begin
                  state_d = ST_WR;
               end else if (state_q == ST_WR) begin
                  // Commit lands in the first read cycle; wait for it so a
                  // read-after-write to the same offset sees the new value.
                  state_d = ST_RD_HOLD;
               end else begin
                  state_d    = ST_RD_ADDR;
                  dma_addr_d = bus.HADDR[ADDR_W-1:0];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         dma_addr_q  <= '0;
         dma_write_q <= 1'b0;
         dma_wdata_q <= '0;
         hrdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         dma_addr_q  <= dma_addr_d;
         dma_write_q <= dma_write_d;
         dma_wdata_q <= dma_wdata_d;
         hrdata_q    <= hrdata_d;
      end
   end

   assign bus.HREADYOUT = !((state_q == ST_RD_HOLD) ||
                            (state_q == ST_RD_ADDR) ||
                            (state_q == ST_ERR1));
   assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ?
                          HRESP_ERROR : HRESP_OKAY;
   assign bus.HRDATA    = hrdata_q;

   assign dma_addr_o  = dma_addr_q;
   assign dma_write_o = dma_write_q;
   assign dma_wdata_o = dma_wdata_q;

endmodule
`default_nettype wire
